// File: rtl/exec_sequencer_if.sv
// Handshake and strobe bundle between the exec sequencer and the surrounding core.
// The master modport is the sequencer itself; the slave modport is the UART/loader/datapath side.
interface exec_sequencer_if;

   logic        rx_ready;
   logic [7:0]  rx_data;
   logic        load_done;
   logic        mem_busy;
   logic        is_out;
   logic        tx_busy;
   logic        stop_req;

   logic [1:0]  mode;
   logic [2:0]  stage;
   logic        latch_fd;
   logic        latch_de;
   logic        latch_em;
   logic        latch_mw;
   logic        pc_we;
   logic        reg_we;
   logic        out_we;
   logic [31:0] retired;

   modport master (
      input  rx_ready, rx_data, load_done, mem_busy, is_out, tx_busy, stop_req,
      output mode, stage, latch_fd, latch_de, latch_em, latch_mw, pc_we, reg_we, out_we,
             retired
   );

   modport slave (
      output rx_ready, rx_data, load_done, mem_busy, is_out, tx_busy, stop_req,
      input  mode, stage, latch_fd, latch_de, latch_em, latch_mw, pc_we, reg_we, out_we,
             retired
   );

endinterface

// File: rtl/exec_sequencer.sv
// Multi-cycle CPU control FSM: run mode (idle/load/exec/halt) plus per-instruction stage
// sequencing with registered one-cycle latch strobes and a retired-instruction counter.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | waiting for START_BYTE on the UART receiver
// ST_LOAD     | fetch loader writing instruction memory, wait for load_done
// ST_FETCH    | wait FETCH_LAT cycles, then latch_fd
// ST_DECODE   | wait DECODE_LAT cycles, then latch_de
// ST_EXECUTE  | wait EXEC_LAT cycles, then latch_em
// ST_MEMORY   | wait >= MEM_LAT cycles and !mem_busy, then latch_mw + pc_we
// ST_W0       | writeback: hold while UART tx is busy, then reg_we (+ out_we)
// ST_W1       | retire; halt on stop_req, otherwise back to fetch
// ST_HALT     | terminal until reset
module exec_sequencer #(
   parameter logic [7:0]  START_BYTE = 8'hAA,
   parameter int unsigned FETCH_LAT  = 0,
   parameter int unsigned DECODE_LAT = 0,
   parameter int unsigned EXEC_LAT   = 3,
   parameter int unsigned MEM_LAT    = 0
) (
   input logic               clk_i,
   input logic               rstn_i,
   exec_sequencer_if.master  bus
);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FETCH,
      ST_DECODE,
      ST_EXECUTE,
      ST_MEMORY,
      ST_W0,
      ST_W1,
      ST_HALT
   } state_t;

   localparam logic [3:0] FETCH_LAT_C  = FETCH_LAT[3:0];
   localparam logic [3:0] DECODE_LAT_C = DECODE_LAT[3:0];
   localparam logic [3:0] EXEC_LAT_C   = EXEC_LAT[3:0];
   localparam logic [3:0] MEM_LAT_C    = MEM_LAT[3:0];

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  cnt_inc;
   logic [31:0] retired_q, retired_d;
   logic        retire;

   logic latch_fd_q, latch_fd_d;
   logic latch_de_q, latch_de_d;
   logic latch_em_q, latch_em_d;
   logic latch_mw_q, latch_mw_d;
   logic pc_we_q,    pc_we_d;
   logic reg_we_q,   reg_we_d;
   logic out_we_q,   out_we_d;

   assign cnt_inc   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
   assign retired_d = retired_q + 32'd1;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         latch_fd_q <= 1'b0;
         latch_de_q <= 1'b0;
         latch_em_q <= 1'b0;
         latch_mw_q <= 1'b0;
         pc_we_q    <= 1'b0;
         reg_we_q   <= 1'b0;
         out_we_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         latch_fd_q <= latch_fd_d;
         latch_de_q <= latch_de_d;
         latch_em_q <= latch_em_d;
         latch_mw_q <= latch_mw_d;
         pc_we_q    <= pc_we_d;
         reg_we_q   <= reg_we_d;
         out_we_q   <= out_we_d;
      end
   end

   // Only written on retire so a value preloaded from outside survives until the next one.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         retired_q <= 32'd0;
      end else if (retire) begin
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      retire     = 1'b0;
      latch_fd_d = 1'b0;
      latch_de_d = 1'b0;
      latch_em_d = 1'b0;
      latch_mw_d = 1'b0;
      pc_we_d    = 1'b0;
      reg_we_d   = 1'b0;
      out_we_d   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.rx_ready && (bus.rx_data == START_BYTE)) begin
               state_d = ST_LOAD;
            end
         end

         ST_LOAD: begin
            if (bus.load_done) begin
               state_d = ST_FETCH;
               cnt_d   = 4'd0;
            end
         end

         ST_FETCH: begin
            if (cnt_q == FETCH_LAT_C) begin
               latch_fd_d = 1'b1;
               state_d    = ST_DECODE;
               cnt_d      = 4'd0;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         ST_DECODE: begin
            if (cnt_q == DECODE_LAT_C) begin
               latch_de_d = 1'b1;
               state_d    = ST_EXECUTE;
               cnt_d      = 4'd0;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         ST_EXECUTE: begin
            if (cnt_q == EXEC_LAT_C) begin
               latch_em_d = 1'b1;
               state_d    = ST_MEMORY;
               cnt_d      = 4'd0;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         // The counter parks at MEM_LAT, so "at least MEM_LAT cycles" is an equality test.
         ST_MEMORY: begin
            if (cnt_q == MEM_LAT_C) begin
               if (!bus.mem_busy) begin
                  latch_mw_d = 1'b1;
                  pc_we_d    = 1'b1;
                  state_d    = ST_W0;
                  cnt_d      = 4'd0;
               end
            end else begin
               cnt_d = cnt_inc;
            end
         end

         ST_W0: begin
            if (!(bus.is_out && bus.tx_busy)) begin
               reg_we_d = 1'b1;
               out_we_d = bus.is_out;
               state_d  = ST_W1;
            end
         end

         ST_W1: begin
            retire  = 1'b1;
            cnt_d   = 4'd0;
            state_d = bus.stop_req ? ST_HALT : ST_FETCH;
         end

         ST_HALT: begin
            state_d = ST_HALT;
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_comb begin
      bus.mode  = 2'd0;
      bus.stage = 3'd0;
      unique case (state_q)
         ST_IDLE:    begin bus.mode = 2'd0; bus.stage = 3'd0; end
         ST_LOAD:    begin bus.mode = 2'd1; bus.stage = 3'd0; end
         ST_FETCH:   begin bus.mode = 2'd2; bus.stage = 3'd0; end
         ST_DECODE:  begin bus.mode = 2'd2; bus.stage = 3'd1; end
         ST_EXECUTE: begin bus.mode = 2'd2; bus.stage = 3'd2; end
         ST_MEMORY:  begin bus.mode = 2'd2; bus.stage = 3'd3; end
         ST_W0:      begin bus.mode = 2'd2; bus.stage = 3'd4; end
         ST_W1:      begin bus.mode = 2'd2; bus.stage = 3'd4; end
         ST_HALT:    begin bus.mode = 2'd3; bus.stage = 3'd5; end
         default:    begin bus.mode = 2'd0; bus.stage = 3'd0; end
      endcase
   end

   assign bus.latch_fd = latch_fd_q;
   assign bus.latch_de = latch_de_q;
   assign bus.latch_em = latch_em_q;
   assign bus.latch_mw = latch_mw_q;
   assign bus.pc_we    = pc_we_q;
   assign bus.reg_we   = reg_we_q;
   assign bus.out_we   = out_we_q;
   assign bus.retired  = retired_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: a vector table for the nominal instruction flow, then
// hand-written sequences for memory/tx back-pressure, halt, async reset and retired wrap.
module tb_exec_sequencer;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   exec_sequencer_if bus();

   exec_sequencer dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // strobe vector bit order: {fd, de, em, mw, pc, reg, out}
   localparam int B_FD  = 6;
   localparam int B_DE  = 5;
   localparam int B_EM  = 4;
   localparam int B_MW  = 3;
   localparam int B_REG = 1;

   localparam logic [6:0] S_NO   = 7'b0000000;
   localparam logic [6:0] S_FD   = 7'b1000000;
   localparam logic [6:0] S_DE   = 7'b0100000;
   localparam logic [6:0] S_EM   = 7'b0010000;
   localparam logic [6:0] S_MWPC = 7'b0001100;
   localparam logic [6:0] S_REG  = 7'b0000010;
   localparam logic [6:0] S_RO   = 7'b0000011;

   typedef struct {
      logic        rr;
      logic [7:0]  rd;
      logic        ld;
      logic        mb;
      logic        io;
      logic        txb;
      logic        sr;
      logic [1:0]  mode;
      logic [2:0]  stage;
      logic [6:0]  strb;
      logic [31:0] ret;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rr, input logic [7:0] rd,
                               input logic ld, input logic mb, input logic io,
                               input logic txb, input logic sr,
                               input logic [1:0] m, input logic [2:0] s,
                               input logic [6:0] st, input logic [31:0] r);
      vec_t v;
      v.rr = rr; v.rd = rd; v.ld = ld; v.mb = mb; v.io = io; v.txb = txb; v.sr = sr;
      v.mode = m; v.stage = s; v.strb = st; v.ret = r;
      return v;
   endfunction

   function automatic logic [6:0] strobes();
      return {bus.latch_fd, bus.latch_de, bus.latch_em, bus.latch_mw,
              bus.pc_we, bus.reg_we, bus.out_we};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rr, input logic [7:0] rd, input logic ld,
                        input logic mb, input logic io, input logic txb, input logic sr);
      bus.rx_ready  = rr;
      bus.rx_data   = rd;
      bus.load_done = ld;
      bus.mem_busy  = mb;
      bus.is_out    = io;
      bus.tx_busy   = txb;
      bus.stop_req  = sr;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_until(input int bit_idx, input int budget, input string name);
      logic [6:0] s;
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         step();
         s = strobes();
         if (s[bit_idx]) seen = 1'b1;
      end
      n_cmp++;
      if (!seen) begin
         n_err++;
         $display("FAIL %s: strobe bit %0d not seen within %0d cycles", name, bit_idx, budget);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // inputs: rr rd ld mb io txb sr | expected after the edge: mode stage strobes retired
      vecs.push_back(mk(1, 8'h55, 0, 0, 0, 0, 0, 2'd0, 3'd0, S_NO,   0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 2'd0, 3'd0, S_NO,   0));
      vecs.push_back(mk(1, 8'hAA, 0, 0, 0, 0, 0, 2'd1, 3'd0, S_NO,   0));
      vecs.push_back(mk(1, 8'hAA, 0, 0, 0, 0, 0, 2'd1, 3'd0, S_NO,   0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 2'd2, 3'd0, S_NO,   0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 2'd2, 3'd1, S_FD,   0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 2'd2, 3'd2, S_DE,   0));
      vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 2'd2, 3'd2, S_NO,   0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 2'd2, 3'd2, S_NO,   0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 2'd2, 3'd2, S_NO,   0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 2'd2, 3'd3, S_EM,   0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 2'd2, 3'd4, S_MWPC, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 2'd2, 3'd4, S_REG,  0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 2'd2, 3'd0, S_NO,   1));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 2'd2, 3'd1, S_FD,   1));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 2'd2, 3'd2, S_DE,   1));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 2'd2, 3'd2, S_NO,   1));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 2'd2, 3'd2, S_NO,   1));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 2'd2, 3'd2, S_NO,   1));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 2'd2, 3'd3, S_EM,   1));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 2'd2, 3'd4, S_MWPC, 1));
      vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 2'd2, 3'd4, S_RO,   1));
      vecs.push_back(mk(0, 8'h00, 0, 1, 0, 1, 0, 2'd2, 3'd0, S_NO,   2));
      vecs.push_back(mk(1, 8'hAA, 0, 0, 0, 0, 0, 2'd2, 3'd1, S_FD,   2));

      rstn = 1'b0;
      drive(0, 8'h00, 0, 0, 0, 0, 0);
      repeat (2) step();
      check("reset_mode",    bus.mode,    2'd0);
      check("reset_strobes", strobes(),   S_NO);
      #2 rstn = 1'b1;
      #1;
      check("idle_mode",    bus.mode,    2'd0);
      check("idle_stage",   bus.stage,   3'd0);
      check("idle_strobes", strobes(),   S_NO);
      check("idle_retired", bus.retired, 32'd0);

      foreach (vecs[i]) begin
         drive(vecs[i].rr, vecs[i].rd, vecs[i].ld, vecs[i].mb, vecs[i].io,
               vecs[i].txb, vecs[i].sr);
         step();
         check($sformatf("vec%0d_mode", i),    bus.mode,    vecs[i].mode);
         check($sformatf("vec%0d_stage", i),   bus.stage,   vecs[i].stage);
         check($sformatf("vec%0d_strobes", i), strobes(),   vecs[i].strb);
         check($sformatf("vec%0d_retired", i), bus.retired, vecs[i].ret);
      end

      // third instruction: mem_busy for 3 cycles on entering MEMORY
      drive(0, 8'h00, 0, 0, 0, 0, 0);
      run_until(B_EM, 20, "third_em");
      bus.mem_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("membusy_wait%0d", i), strobes(), S_NO);
         check($sformatf("membusy_stage%0d", i), bus.stage, 3'd3);
      end
      bus.mem_busy = 1'b0;
      step();
      check("membusy_release", strobes(), S_MWPC);

      // W0 held by tx_busy for 5 cycles
      bus.is_out  = 1'b1;
      bus.tx_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("txbusy_wait%0d", i), strobes(), S_NO);
         check($sformatf("txbusy_stage%0d", i), bus.stage, 3'd4);
      end
      bus.tx_busy  = 1'b0;
      bus.stop_req = 1'b1;
      step();
      check("txbusy_release", strobes(), S_RO);
      step();
      check("halt_mode",    bus.mode,    2'd3);
      check("halt_stage",   bus.stage,   3'd5);
      check("halt_retired", bus.retired, 32'd3);
      check("halt_strobes", strobes(),   S_NO);

      for (int i = 0; i < 100; i++) begin
         drive((i % 3) == 0, 8'hAA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
         step();
         check("halt_quiet", strobes(), S_NO);
      end
      check("halt_mode_end",    bus.mode,    2'd3);
      check("halt_retired_end", bus.retired, 32'd3);

      // async reset out of HALT, no clock edge in between
      drive(0, 8'h00, 0, 0, 0, 0, 0);
      #2 rstn = 1'b0;
      #1;
      check("async_halt_mode",    bus.mode,    2'd0);
      check("async_halt_stage",   bus.stage,   3'd0);
      check("async_halt_retired", bus.retired, 32'd0);
      step();
      #3 rstn = 1'b1;

      // start again and reset while EXECUTE is waiting with latch_de still high
      drive(1, 8'hAA, 0, 0, 0, 0, 0);
      step();
      drive(0, 8'h00, 1, 0, 0, 0, 0);
      step();
      check("restart_mode", bus.mode, 2'd2);
      drive(0, 8'h00, 0, 0, 0, 0, 0);
      run_until(B_DE, 10, "restart_de");
      check("pre_reset_stage", bus.stage, 3'd2);
      #2 rstn = 1'b0;
      #1;
      check("async_exec_strobes", strobes(),   S_NO);
      check("async_exec_mode",    bus.mode,    2'd0);
      check("async_exec_stage",   bus.stage,   3'd0);
      step();
      check("held_reset_strobes", strobes(), S_NO);
      #3 rstn = 1'b1;
      #1;
      check("post_reset_mode",    bus.mode,    2'd0);
      check("post_reset_retired", bus.retired, 32'd0);

      // retired wraps from all-ones to zero
      drive(1, 8'hAA, 0, 0, 0, 0, 0);
      step();
      drive(0, 8'h00, 1, 0, 0, 0, 0);
      step();
      drive(0, 8'h00, 0, 0, 0, 0, 0);
      run_until(B_MW, 20, "wrap_mw");
      force dut.retired_q = 32'hFFFF_FFFF;
      #1;
      release dut.retired_q;
      run_until(B_REG, 5, "wrap_reg");
      step();
      check("wrap_retired", bus.retired, 32'd0);
      check("wrap_stage",   bus.stage,   3'd0);
      check("wrap_mode",    bus.mode,    2'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
